// File: rtl/out_bus_fifo_if.sv
// Output-event bus plus host-side FIFO drain port for out_bus_fifo.
// The core drives out_req/out_data; the host drives rd_en/clr_ovf.
interface out_bus_fifo_if #(
  parameter int AW = 4
);
  logic          out_req;
  logic [7:0]    out_data;
  logic          out_ack;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [AW:0]   fifo_level;
  logic          overflow;
  logic          clr_ovf;

  modport master (
    output out_req, out_data, rd_en, clr_ovf,
    input  out_ack, rd_data, rd_valid, fifo_level, overflow
  );

  modport slave (
    input  out_req, out_data, rd_en, clr_ovf,
    output out_ack, rd_data, rd_valid, fifo_level, overflow
  );
endinterface

// File: rtl/out_bus_fifo.sv
// 4-phase OUT_REQ/OUT_ACK receiver feeding a first-word-fall-through byte FIFO.
// Define OUT_BUS_FIFO_DROP_ON_FULL_EN to acknowledge-and-drop when full (sticky overflow).
module out_bus_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           CLK,
  input  logic           RST,
  out_bus_fifo_if.slave  bus
);

`ifdef OUT_BUS_FIFO_DROP_ON_FULL_EN
  localparam bit DROP_ON_FULL = 1'b1;
`else
  localparam bit DROP_ON_FULL = 1'b0;
`endif

  typedef enum logic {IDLE, ACK_HI} state_t;

  state_t          state_reg, state_next;
  logic            req_meta_reg, req_s_reg;
  logic [7:0]      mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     level_reg;
  logic            full, empty;
  logic            wr_en, pop_en, drop;

  assign full   = (level_reg == (AW+1)'(DEPTH));
  assign empty  = (level_reg == '0);
  assign pop_en = bus.rd_en && !empty;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      req_meta_reg <= 1'b0;
      req_s_reg    <= 1'b0;
    end else begin
      req_meta_reg <= bus.out_req;
      req_s_reg    <= req_meta_reg;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // In lossless mode a full FIFO keeps the FSM in IDLE until a pop frees a slot.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_s_reg && (!full || DROP_ON_FULL)) state_next = ACK_HI;
      ACK_HI:  if (!req_s_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_en = 1'b0;
    drop  = 1'b0;
    if (state_reg == IDLE && req_s_reg) begin
      if (!full) wr_en = 1'b1;
      else       drop  = DROP_ON_FULL;
    end
  end

  assign bus.out_ack = (state_reg == ACK_HI);

  always_ff @(posedge CLK) begin
    if (wr_en) mem_reg[wr_ptr_reg] <= bus.out_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop_en})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign bus.rd_valid   = !empty;
  assign bus.rd_data    = empty ? 8'h00 : mem_reg[rd_ptr_reg];
  assign bus.fifo_level = level_reg;

`ifdef OUT_BUS_FIFO_DROP_ON_FULL_EN
  logic ovf_reg;

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)             ovf_reg <= 1'b0;
    else if (drop)        ovf_reg <= 1'b1;
    else if (bus.clr_ovf) ovf_reg <= 1'b0;
  end

  assign bus.overflow = ovf_reg;
`else
  logic unused_inputs;
  assign unused_inputs = ^{bus.clr_ovf, drop};
  assign bus.overflow  = 1'b0;
`endif

endmodule
